// File: rtl/lfsr_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_rr_scheduler
// Description : Round-robin sharing of one external lfsr_16 among N_REQ
//               requesters; steps the LFSR, samples it, returns a tagged word.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_rr_scheduler #(
    parameter int N_REQ    = 4,
    parameter int ID_W     = 2,
    parameter int STEP_CNT = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             busy,
    output logic             lfsr_en,
    input  logic [15:0]      lfsr_in,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ID_W-1:0]  rsp_id,
    output logic [15:0]      rsp_data
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STEP    = 2'd1,
        ST_LOAD    = 2'd2,
        ST_DELIVER = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(STEP_CNT - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [ID_W-1:0]  c_last_rst = ID_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] c_one_hot  = N_REQ'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N_REQ-1:0]   r_gnt;
    logic [ID_W-1:0]    r_id;
    logic [ID_W-1:0]    r_last;
    logic [15:0]        r_data;
    logic               r_valid;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_found;
    logic [ID_W-1:0]    w_pick;
    logic [ID_W-1:0]    w_idx;

    // Rotating priority search: starts one past the last served requester.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = ID_W'((int'(r_last) + k) % N_REQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_STEP;
                end
            end
            ST_STEP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_DELIVER;
            end
            ST_DELIVER: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Grant, counter and response registers; owner is only released on handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gnt   <= '0;
            r_id    <= '0;
            r_last  <= c_last_rst;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_gnt <= c_one_hot << w_pick;
                        r_id  <= w_pick;
                        r_cnt <= c_cnt_init;
                    end
                end
                ST_STEP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                ST_LOAD: begin
                    r_data  <= lfsr_in;
                    r_valid <= 1'b1;
                end
                ST_DELIVER: begin
                    if (rsp_ready) begin
                        r_valid <= 1'b0;
                        r_gnt   <= '0;
                        r_last  <= r_id;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign busy      = (r_state != ST_IDLE);
    assign lfsr_en   = (r_state == ST_STEP);
    assign rsp_valid = r_valid;
    assign rsp_id    = r_id;
    assign rsp_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_rr_scheduler
// Description : Scoreboard bench for lfsr_rr_scheduler with an incrementing
//               lfsr_16 stand-in and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_rr_scheduler;

    localparam int N_REQ    = 4;
    localparam int ID_W     = 2;
    localparam int STEP_CNT = 4;
    localparam int CNT_W    = 5;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic             busy;
    logic             lfsr_en;
    logic [15:0]      lfsr_stub = 16'h0001;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [ID_W-1:0]  rsp_id;
    logic [15:0]      rsp_data;

    always #5 clk = ~clk;

    lfsr_rr_scheduler #(
        .N_REQ    (N_REQ),
        .ID_W     (ID_W),
        .STEP_CNT (STEP_CNT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .gnt       (gnt),
        .busy      (busy),
        .lfsr_en   (lfsr_en),
        .lfsr_in   (lfsr_stub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    // Stand-in for lfsr_16: counts up once per enabled edge.
    always @(posedge clk) begin
        if (lfsr_en) lfsr_stub <= lfsr_stub + 16'd1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction in flight, timed by a countdown.
    typedef struct {
        int id;
        int data;
    } rsp_t;

    rsp_t        exp_q[$];
    bit          m_active;
    int          m_wait;
    int          m_id;
    int          m_last;
    logic [15:0] m_lfsr;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 1'b0;
            m_wait   = 0;
            m_id     = 0;
            m_last   = N_REQ - 1;
            m_lfsr   = lfsr_stub;
            exp_q.delete();
        end else if (!m_active) begin
            if (req != '0) begin
                for (int k = 1; k <= N_REQ; k++) begin
                    if (req[(m_last + k) % N_REQ]) begin
                        m_id = (m_last + k) % N_REQ;
                        break;
                    end
                end
                m_active = 1'b1;
                m_wait   = STEP_CNT + 1;
                m_lfsr   = m_lfsr + 16'(STEP_CNT);
                exp_q.push_back('{m_id, int'(m_lfsr)});
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (rsp_ready) begin
            m_active = 1'b0;
            m_last   = m_id;
        end
    end

    // Monitor: cycle-level control checks plus scoreboard pop on handshake.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("busy", int'(busy), int'(m_active));
            chk("lfsr_en", int'(lfsr_en), int'(m_active && m_wait >= 2));
            chk("gnt", int'(gnt), m_active ? (1 << m_id) : 0);
            chk("rsp_valid", int'(rsp_valid), int'(m_active && m_wait == 0));
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    chk("rsp_id", int'(rsp_id), exp_q[0].id);
                    chk("rsp_data", int'(rsp_data), exp_q[0].data);
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_for(input bit val);
        for (int i = 0; i < 60; i++) begin
            tick();
            if (busy == val) break;
        end
        chk("wait_busy", int'(busy), int'(val));
    endtask

    task automatic chk_idle_outputs();
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_lfsr_en", int'(lfsr_en), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
    endtask

    // Asynchronous pulse placed mid-cycle so the clear is seen between edges.
    task automatic do_reset(input logic [N_REQ-1:0] next_req);
        #1;
        reset_n = 1'b0;
        #1;
        chk_idle_outputs();
        req = next_req;
        tick();
        tick();
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        req       = '1;
        rsp_ready = 1'b0;
        run(3);
        #1;
        chk_idle_outputs();
        reset_n = 1'b1;
        wait_for(1'b1);
        chk("first_gnt", int'(gnt), 4'b0001);
        rsp_ready = 1'b1;
        req       = '0;
        wait_for(1'b0);

        // Single requester, always-ready consumer.
        do_reset(4'b0000);
        req = 4'b0100;
        wait_for(1'b1);
        chk("single_gnt", int'(gnt), 4'b0100);
        req = '0;
        run(10);

        // All requesting: strict rotation.
        do_reset(4'b1111);
        rsp_ready = 1'b1;
        run(40);

        // Long back-pressure in DELIVER.
        req       = 4'b0001;
        rsp_ready = 1'b0;
        wait_for(1'b1);
        req = '0;
        run(20);
        rsp_ready = 1'b1;
        run(3);

        // Rotation past a waiting requester, then a dropped request.
        req = 4'b0010;
        wait_for(1'b1);
        tick();
        req = 4'b1010;
        wait_for(1'b0);
        wait_for(1'b1);
        chk("rot_gnt3", int'(gnt), 4'b1000);
        tick();
        req = 4'b0010;
        wait_for(1'b0);
        wait_for(1'b1);
        chk("rot_gnt1", int'(gnt), 4'b0010);
        req = '0;
        wait_for(1'b0);

        // Reset in the STEP phase of the second transaction.
        req = 4'b1111;
        wait_for(1'b1);
        wait_for(1'b0);
        wait_for(1'b1);
        tick();
        do_reset(4'b1100);
        wait_for(1'b1);
        chk("post_rst_gnt", int'(gnt), 4'b0100);

        // Randomized traffic and back-pressure.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) req = N_REQ'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 9) < 6);
            tick();
        end

        req       = '0;
        rsp_ready = 1'b1;
        run(20);
        chk("drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
